// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned BCD_BASE      = 10;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // True when a 4-bit nibble is a legal BCD digit.
    function automatic logic digit_is_bcd(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction: a - b - borrow_in with decimal wrap.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   borrow_in,
    output logic [BCD_DIGIT_W-1:0] diff_c,
    output logic                   borrow_out_c
);

    localparam int unsigned TW = BCD_DIGIT_W + 1;

    logic [TW-1:0] t;

    // Signed difference in TW bits; a negative result wraps by adding the base.
    always_comb begin
        t            = TW'(a) - TW'(b) - TW'(borrow_in);
        borrow_out_c = t[TW-1];
        diff_c       = borrow_out_c ? BCD_DIGIT_W'(t + TW'(BCD_BASE)) : t[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing |A-B| with sign and invalid-digit flag.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NDIG*BCD_DIGIT_W-1:0] A,
    input  logic [NDIG*BCD_DIGIT_W-1:0] B,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NDIG*BCD_DIGIT_W-1:0] diff,
    output logic                        neg,
    output logic                        err
);

    localparam int unsigned W     = NDIG * BCD_DIGIT_W;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t                  state;
    logic [W-1:0]            a_sh;
    logic [W-1:0]            b_sh;
    logic [W-1:0]            r_sh;
    logic [IDX_W-1:0]        idx;
    logic                    borrow;

    logic [BCD_DIGIT_W-1:0]  sub_a_c;
    logic [BCD_DIGIT_W-1:0]  sub_b_c;
    logic [BCD_DIGIT_W-1:0]  sub_diff_c;
    logic                    sub_borrow_c;
    logic [W-1:0]            r_next_c;
    logic                    operands_ok_c;

    // Single digit subtractor shared by the SUB and NEG passes.
    bcd_digit_sub u_digit_sub (
        .a            (sub_a_c),
        .b            (sub_b_c),
        .borrow_in    (borrow),
        .diff_c       (sub_diff_c),
        .borrow_out_c (sub_borrow_c)
    );

    // SUB takes A_i - B_i; NEG takes 0 - R_i to ten's-complement the result.
    always_comb begin
        sub_a_c = a_sh[BCD_DIGIT_W-1:0];
        sub_b_c = b_sh[BCD_DIGIT_W-1:0];
        if (state == NEG) begin
            sub_a_c = '0;
            sub_b_c = r_sh[BCD_DIGIT_W-1:0];
        end
    end

    // Result register shifts right one digit, new digit enters at the top.
    always_comb begin
        r_next_c = r_sh >> BCD_DIGIT_W;
        r_next_c[W-1 -: BCD_DIGIT_W] = sub_diff_c;
    end

    // Flag any non-BCD nibble in the offered operands.
    always_comb begin
        operands_ok_c = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (!digit_is_bcd(A[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !digit_is_bcd(B[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                operands_ok_c = 1'b0;
            end
        end
    end

    // Control FSM with datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        idx      <= '0;
                        borrow   <= 1'b0;
                        in_ready <= 1'b0;
                        if (operands_ok_c) begin
                            state <= SUB;
                        end else begin
                            state <= DONE;
                            diff  <= '0;
                            neg   <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
                SUB: begin
                    r_sh   <= r_next_c;
                    a_sh   <= a_sh >> BCD_DIGIT_W;
                    b_sh   <= b_sh >> BCD_DIGIT_W;
                    borrow <= sub_borrow_c;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (sub_borrow_c) begin
                            state  <= NEG;
                            borrow <= 1'b0;
                        end else begin
                            state <= DONE;
                            diff  <= r_next_c;
                            neg   <= 1'b0;
                            err   <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                NEG: begin
                    r_sh   <= r_next_c;
                    borrow <= sub_borrow_c;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= DONE;
                        diff  <= r_next_c;
                        neg   <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE.
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized self-checking bench for bcd_serial_subtractor against a decimal model.
module tb_bcd_serial_subtractor;

    localparam int NDIG = 4;
    localparam int W    = NDIG * 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_diff;
    logic         exp_neg;
    logic         exp_err;

    bcd_serial_subtractor #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .neg       (neg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Decimal value of a packed BCD word (only meaningful when all digits are legal).
    function automatic int bcd_to_int(input logic [W-1:0] x);
        int v = 0;
        for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad_digit(input logic [W-1:0] x);
        bit bad = 0;
        for (int i = 0; i < NDIG; i++) if (x[i*4 +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    // Behavioural reference: plain decimal arithmetic plus the documented latencies.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic n, output logic e, output int lat);
        int av, bv;
        if (has_bad_digit(a) || has_bad_digit(b)) begin
            d = '0; n = 1'b0; e = 1'b1; lat = 1;
        end else begin
            av = bcd_to_int(a);
            bv = bcd_to_int(b);
            e  = 1'b0;
            n  = (av < bv);
            d  = int_to_bcd(n ? bv - av : av - bv);
            lat = n ? 2 * NDIG + 1 : NDIG + 1;
        end
    endtask

    // Whenever a result is presented it must match the model for the accepted operands.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("mon_diff", 32'(diff), 32'(exp_diff));
            check("mon_neg", 32'(neg), 32'(exp_neg));
            check("mon_err", 32'(err), 32'(exp_err));
            check("mon_in_ready", 32'(in_ready), 32'd0);
        end
    end

    // One full transaction: offer, measure latency, optionally stall, then handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit use_lit, input logic [W-1:0] lit_diff,
                         input logic lit_neg, input logic lit_err, input int lit_lat);
        logic [W-1:0] md;
        logic mn, me;
        int ml, lat, waited;
        bit seen;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        model(a, b, md, mn, me, ml);
        exp_diff = md; exp_neg = mn; exp_err = me;
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        if ($urandom_range(1, 0) == 1) begin
            A = W'($urandom); B = W'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) seen = 1;
            else check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        if (!seen) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            return;
        end
        check("latency", 32'(lat), 32'(ml));
        if (use_lit) begin
            check("lit_diff", 32'(diff), 32'(lit_diff));
            check("lit_neg", 32'(neg), 32'(lit_neg));
            check("lit_err", 32'(err), 32'(lit_err));
            check("lit_latency", 32'(lat), 32'(lit_lat));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_diff", 32'(diff), 32'(md));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            if (in_valid) begin
                A = W'($urandom); B = W'($urandom);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_diff_kept", 32'(diff), 32'(md));
    endtask

    initial begin
        logic [W-1:0] md, ra, rb;
        logic mn, me;
        int ml;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        exp_diff = '0; exp_neg = 1'b0; exp_err = 1'b0;

        // Pin the model to hand-computed values.
        model(16'h5821, 16'h1234, md, mn, me, ml);
        check("model_5821_1234", {md, 7'd0, mn, 7'd0, me}, {16'h4587, 16'h0000});
        check("model_lat_pos", 32'(ml), 32'd5);
        model(16'h0000, 16'h9999, md, mn, me, ml);
        check("model_0_9999", {md, 7'd0, mn, 7'd0, me}, {16'h9999, 16'h0100});
        check("model_lat_neg", 32'(ml), 32'd9);
        model(16'h12A4, 16'h0000, md, mn, me, ml);
        check("model_err", {md, 7'd0, mn, 7'd0, me}, {16'h0000, 16'h0001});

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {16'(diff), 7'd0, neg, 7'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h5821, 16'h1234, 0, 1, 16'h4587, 1'b0, 1'b0, 5);
        do_op(16'h0123, 16'h0456, 0, 1, 16'h0333, 1'b1, 1'b0, 9);
        do_op(16'h0000, 16'h9999, 1, 1, 16'h9999, 1'b1, 1'b0, 9);
        do_op(16'h1000, 16'h0001, 0, 1, 16'h0999, 1'b0, 1'b0, 5);
        do_op(16'h12A4, 16'h0000, 0, 1, 16'h0000, 1'b0, 1'b1, 1);
        do_op(16'h4444, 16'h4444, 0, 1, 16'h0000, 1'b0, 1'b0, 5);
        do_op(16'h0777, 16'h0123, 3, 1, 16'h0654, 1'b0, 1'b0, 5);

        // Reset during the second SUB cycle aborts the operation.
        @(negedge clk);
        A = 16'h5821; B = 16'h1234; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", {16'(diff), 7'd0, neg, 7'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        do_op(16'h5821, 16'h1234, 0, 1, 16'h4587, 1'b0, 1'b0, 5);

        // Randomized operands, occasionally with illegal digits.
        for (int k = 0; k < 60; k++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < NDIG; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(9, 0));
                rb[i*4 +: 4] = 4'($urandom_range(9, 0));
            end
            if ($urandom_range(9, 0) == 0) ra[$urandom_range(NDIG-1, 0)*4 +: 4] = 4'($urandom_range(15, 10));
            if ($urandom_range(9, 0) == 0) rb[$urandom_range(NDIG-1, 0)*4 +: 4] = 4'($urandom_range(15, 10));
            if ($urandom_range(7, 0) == 0) rb = ra;
            do_op(ra, rb, int'($urandom_range(3, 0)), 0, '0, 1'b0, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
